// File: rtl/src_dbuf_if.sv
// Port bundle for src_dbuf: DMA fill side, compute read side, status and a debug view of bank occupancy.
// Each side is a request qualified by its ready: a request is taken only on a clock edge where
// its strobe (src_v / exec) and its ready (src_rdy / exec_rdy) are both high; otherwise it is dropped.
interface src_dbuf_if #(
    parameter int BUS_W  = 64,
    parameter int ELEM_W = 32,
    parameter int DEPTH  = 16
);
    localparam int LANES = BUS_W / ELEM_W;
    localparam int AW    = $clog2(DEPTH);
    localparam int IW    = $clog2(DEPTH * LANES);

    logic              src_v;
    logic [AW-1:0]     src_a;
    logic [BUS_W-1:0]  src_d;
    logic              src_last;
    logic              src_rdy;

    logic              exec;
    logic [IW-1:0]     ia;
    logic              exec_last;
    logic              exec_rdy;
    logic [ELEM_W-1:0] d;
    logic              d_v;

    logic              err;
    logic [1:0]        occ;

    modport master (
        output src_v, src_a, src_d, src_last, exec, ia, exec_last,
        input  src_rdy, exec_rdy, d, d_v, err, occ
    );

    modport slave (
        input  src_v, src_a, src_d, src_last, exec, ia, exec_last,
        output src_rdy, exec_rdy, d, d_v, err, occ
    );
endinterface

// File: rtl/src_dbuf.sv
// Ping-pong source operand buffer: DMA fills one bank while compute reads elements from the other.
// Optional SRC_DBUF_ERR_EN enables the sticky protocol-error flag; otherwise err is tied low.
module src_dbuf #(
    parameter int BUS_W  = 64,
    parameter int ELEM_W = 32,
    parameter int DEPTH  = 16
) (
    input logic      clk,
    input logic      reset,
    src_dbuf_if.slave bus
);
    localparam int LANES = BUS_W / ELEM_W;
    localparam int AW    = $clog2(DEPTH);
    localparam int IW    = $clog2(DEPTH * LANES);
    localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_t;

    occ_t occ_q, occ_d;
    logic wr_sel, rd_sel;
    logic wr_acc, rd_acc, commit, release_bank;
    logic src_rdy, exec_rdy;

    logic [BUS_W-1:0] mem0 [DEPTH];
    logic [BUS_W-1:0] mem1 [DEPTH];
    logic [BUS_W-1:0] rd_q;
    logic             d_v_q;
    logic [AW-1:0]    rd_word;

    // Readies come from the occupancy register only, so no input reaches them combinationally.
    assign src_rdy      = (occ_q != OCC_FULL);
    assign exec_rdy     = (occ_q != OCC_EMPTY);
    assign wr_acc       = bus.src_v & src_rdy;
    assign rd_acc       = bus.exec & exec_rdy;
    assign commit       = wr_acc & bus.src_last;
    assign release_bank = rd_acc & bus.exec_last;
    assign rd_word      = bus.ia[IW-1:IW-AW];

    assign bus.src_rdy  = src_rdy;
    assign bus.exec_rdy = exec_rdy;
    assign bus.d_v      = d_v_q;
    assign bus.occ      = occ_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            occ_q  <= OCC_EMPTY;
            wr_sel <= 1'b0;
            rd_sel <= 1'b0;
        end else begin
            occ_q <= occ_d;
            if (commit)       wr_sel <= ~wr_sel;
            if (release_bank) rd_sel <= ~rd_sel;
        end
    end

    always_comb begin
        occ_d = occ_q;
        if (commit && !release_bank) begin
            case (occ_q)
                OCC_EMPTY: occ_d = OCC_ONE;
                OCC_ONE:   occ_d = OCC_FULL;
                default:   occ_d = occ_q;
            endcase
        end else if (release_bank && !commit) begin
            case (occ_q)
                OCC_FULL: occ_d = OCC_ONE;
                OCC_ONE:  occ_d = OCC_EMPTY;
                default:  occ_d = occ_q;
            endcase
        end
    end

    // Bank storage is deliberately not reset; stale words in a partial fill are legal.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            if (wr_sel) mem1[bus.src_a] <= bus.src_d;
            else        mem0[bus.src_a] <= bus.src_d;
        end
    end

    // The read uses the pre-edge rd_sel, so a releasing read still returns from the released bank.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_q  <= '0;
            d_v_q <= 1'b0;
        end else begin
            d_v_q <= rd_acc;
            if (rd_acc) rd_q <= rd_sel ? mem1[rd_word] : mem0[rd_word];
        end
    end

    generate
        if (LANES > 1) begin : g_lanes
            logic [LW-1:0] lane_q;
            always_ff @(posedge clk or posedge reset) begin
                if (reset)       lane_q <= '0;
                else if (rd_acc) lane_q <= bus.ia[LW-1:0];
            end
            assign bus.d = rd_q[lane_q*ELEM_W +: ELEM_W];
        end else begin : g_one_lane
            assign bus.d = rd_q[ELEM_W-1:0];
        end
    endgenerate

`ifdef SRC_DBUF_ERR_EN
    logic err_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) err_q <= 1'b0;
        else if ((bus.src_v & ~src_rdy) | (bus.exec & ~exec_rdy)) err_q <= 1'b1;
    end
    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif
endmodule

// File: tb/tb_src_dbuf.sv
// Directed bench for src_dbuf: fill/read ordering, full and empty blocking, simultaneous commit/release,
// overlapped fill and read streams, and mid-fill reset.
module tb_src_dbuf;
  localparam int BUS_W  = 64;
  localparam int ELEM_W = 32;
  localparam int DEPTH  = 16;

  logic clk = 1'b0;
  logic reset;
  int vectors = 0;
  int miscompares = 0;
  logic exp_err = 1'b0;
  logic [ELEM_W-1:0] exp_q[$];

  src_dbuf_if #(.BUS_W(BUS_W), .ELEM_W(ELEM_W), .DEPTH(DEPTH)) bus();
  src_dbuf #(.BUS_W(BUS_W), .ELEM_W(ELEM_W), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time=%0t, required finish before 200000", $time);
    $fatal(1, "watchdog expired");
  end

  // Word i of a pattern is {hi+i, lo+i}; element ia maps to word ia>>1, lane ia[0].
  function automatic logic [BUS_W-1:0] word_of(input logic [31:0] hi, input logic [31:0] lo, input int i);
    logic [31:0] h, l;
    h = hi + 32'(i);
    l = lo + 32'(i);
    return {h, l};
  endfunction

  function automatic logic [ELEM_W-1:0] elem_of(input logic [31:0] hi, input logic [31:0] lo, input int ia);
    return (ia % 2 == 1) ? hi + 32'(ia / 2) : lo + 32'(ia / 2);
  endfunction

  task automatic idle();
    bus.src_v = 1'b0;
    bus.src_last = 1'b0;
    bus.exec = 1'b0;
    bus.exec_last = 1'b0;
  endtask

  task automatic fill(input logic [31:0] hi, input logic [31:0] lo, input int n, input bit last);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.src_v = 1'b1;
      bus.src_a = 4'(i);
      bus.src_d = word_of(hi, lo, i);
      bus.src_last = last && (i == n - 1);
    end
    @(negedge clk);
    idle();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.src_a = '0;
    bus.src_d = '0;
    bus.ia = '0;
    idle();
    repeat (2) @(negedge clk);
    vectors++;
    if (bus.src_rdy !== 1'b1 || bus.exec_rdy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_rdy: src_rdy=%b exec_rdy=%b, required 1 0", bus.src_rdy, bus.exec_rdy);
    end
    vectors++;
    if (bus.d !== 32'h0 || bus.d_v !== 1'b0 || bus.err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_out: d=%h d_v=%b err=%b, required 0 0 0", bus.d, bus.d_v, bus.err);
    end
    reset = 1'b0;
    @(negedge clk);
    vectors++;
    if (bus.occ !== 2'd0 || bus.src_rdy !== 1'b1 || bus.exec_rdy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release: occ=%0d src_rdy=%b exec_rdy=%b, required 0 1 0", bus.occ, bus.src_rdy, bus.exec_rdy);
    end
  endtask

  task automatic test_fill_read();
    logic [ELEM_W-1:0] e;
    fill(32'h100, 32'h0, 16, 1'b1);
    vectors++;
    if (bus.exec_rdy !== 1'b1 || bus.occ !== 2'd1) begin
      miscompares++;
      $display("FAIL fill_commit: exec_rdy=%b occ=%0d, required 1 1", bus.exec_rdy, bus.occ);
    end
    exp_q.delete();
    for (int k = 0; k <= 32; k++) begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        vectors++;
        if (bus.d_v !== 1'b1 || bus.d !== e) begin
          miscompares++;
          $display("FAIL fill_read ia=%0d: d=%h d_v=%b, required d=%h d_v=1", k - 1, bus.d, bus.d_v, e);
        end
      end
      if (k < 32) begin
        bus.exec = 1'b1;
        bus.ia = 5'(k);
        bus.exec_last = (k == 31);
        exp_q.push_back(elem_of(32'h100, 32'h0, k));
      end else begin
        idle();
      end
    end
    vectors++;
    if (bus.exec_rdy !== 1'b0 || bus.src_rdy !== 1'b1 || bus.occ !== 2'd0) begin
      miscompares++;
      $display("FAIL fill_release: exec_rdy=%b src_rdy=%b occ=%0d, required 0 1 0", bus.exec_rdy, bus.src_rdy, bus.occ);
    end
  endtask

  task automatic test_full();
    logic [ELEM_W-1:0] e;
    fill(32'h200, 32'h300, 16, 1'b1);
    fill(32'h400, 32'h500, 16, 1'b1);
    vectors++;
    if (bus.src_rdy !== 1'b0 || bus.exec_rdy !== 1'b1 || bus.occ !== 2'd2) begin
      miscompares++;
      $display("FAIL full_state: src_rdy=%b exec_rdy=%b occ=%0d, required 0 1 2", bus.src_rdy, bus.exec_rdy, bus.occ);
    end
    @(negedge clk);
    bus.src_v = 1'b1;
    bus.src_a = 4'd0;
    bus.src_d = 64'hDEAD_BEEF_DEAD_BEEF;
    bus.src_last = 1'b1;
    @(negedge clk);
    idle();
`ifdef SRC_DBUF_ERR_EN
    exp_err = 1'b1;
`endif
    vectors++;
    if (bus.err !== exp_err || bus.occ !== 2'd2) begin
      miscompares++;
      $display("FAIL full_drop: err=%b occ=%0d, required %b 2", bus.err, bus.occ, exp_err);
    end
    exp_q.delete();
    for (int k = 0; k <= 2; k++) begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        vectors++;
        if (bus.d_v !== 1'b1 || bus.d !== e) begin
          miscompares++;
          $display("FAIL full_read ia=%0d: d=%h d_v=%b, required d=%h d_v=1", k - 1, bus.d, bus.d_v, e);
        end
      end
      if (k < 2) begin
        bus.exec = 1'b1;
        bus.ia = 5'(k);
        bus.exec_last = (k == 1);
        exp_q.push_back(elem_of(32'h200, 32'h300, k));
      end else begin
        idle();
      end
    end
    vectors++;
    if (bus.occ !== 2'd1 || bus.src_rdy !== 1'b1) begin
      miscompares++;
      $display("FAIL full_release: occ=%0d src_rdy=%b, required 1 1", bus.occ, bus.src_rdy);
    end
  endtask

  task automatic test_simultaneous();
    logic [ELEM_W-1:0] e;
    fill(32'h600, 32'h700, 15, 1'b0);
    @(negedge clk);
    bus.src_v = 1'b1;
    bus.src_a = 4'd15;
    bus.src_d = word_of(32'h600, 32'h700, 15);
    bus.src_last = 1'b1;
    bus.exec = 1'b1;
    bus.ia = 5'd5;
    bus.exec_last = 1'b1;
    @(negedge clk);
    idle();
    vectors++;
    if (bus.d !== 32'h402 || bus.d_v !== 1'b1) begin
      miscompares++;
      $display("FAIL simul_read: d=%h d_v=%b, required 00000402 1", bus.d, bus.d_v);
    end
    vectors++;
    if (bus.occ !== 2'd1 || bus.exec_rdy !== 1'b1 || bus.src_rdy !== 1'b1) begin
      miscompares++;
      $display("FAIL simul_state: occ=%0d exec_rdy=%b src_rdy=%b, required 1 1 1", bus.occ, bus.exec_rdy, bus.src_rdy);
    end
    exp_q.delete();
    for (int k = 0; k <= 32; k++) begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        vectors++;
        if (bus.d_v !== 1'b1 || bus.d !== e) begin
          miscompares++;
          $display("FAIL simul_next ia=%0d: d=%h d_v=%b, required d=%h d_v=1", k - 1, bus.d, bus.d_v, e);
        end
      end
      if (k < 32) begin
        bus.exec = 1'b1;
        bus.ia = 5'(k);
        bus.exec_last = (k == 31);
        exp_q.push_back(elem_of(32'h600, 32'h700, k));
      end else begin
        idle();
      end
    end
  endtask

  task automatic test_exec_empty();
    vectors++;
    if (bus.exec_rdy !== 1'b0 || bus.occ !== 2'd0) begin
      miscompares++;
      $display("FAIL empty_state: exec_rdy=%b occ=%0d, required 0 0", bus.exec_rdy, bus.occ);
    end
    @(negedge clk);
    bus.exec = 1'b1;
    bus.ia = 5'd3;
    @(negedge clk);
    idle();
`ifdef SRC_DBUF_ERR_EN
    exp_err = 1'b1;
`endif
    vectors++;
    if (bus.d_v !== 1'b0 || bus.d !== 32'h60F) begin
      miscompares++;
      $display("FAIL empty_read: d=%h d_v=%b, required 0000060f 0", bus.d, bus.d_v);
    end
    vectors++;
    if (bus.err !== exp_err || bus.occ !== 2'd0) begin
      miscompares++;
      $display("FAIL empty_err: err=%b occ=%0d, required %b 0", bus.err, bus.occ, exp_err);
    end
  endtask

  task automatic test_overlap();
    logic [ELEM_W-1:0] e;
    fill(32'h800, 32'h900, 16, 1'b1);
    exp_q.delete();
    for (int k = 0; k <= 64; k++) begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        vectors++;
        if (bus.d_v !== 1'b1 || bus.d !== e) begin
          miscompares++;
          $display("FAIL overlap k=%0d: d=%h d_v=%b, required d=%h d_v=1", k - 1, bus.d, bus.d_v, e);
        end
      end
      if (k < 16) begin
        bus.src_v = 1'b1;
        bus.src_a = 4'(k);
        bus.src_d = word_of(32'hA00, 32'hB00, k);
        bus.src_last = (k == 15);
      end else begin
        bus.src_v = 1'b0;
        bus.src_last = 1'b0;
      end
      if (k < 64) begin
        bus.exec = 1'b1;
        bus.ia = 5'(k % 32);
        bus.exec_last = (k % 32 == 31);
        if (k < 32) exp_q.push_back(elem_of(32'h800, 32'h900, k));
        else        exp_q.push_back(elem_of(32'hA00, 32'hB00, k - 32));
      end else begin
        idle();
      end
    end
    vectors++;
    if (bus.occ !== 2'd0 || bus.exec_rdy !== 1'b0 || bus.src_rdy !== 1'b1) begin
      miscompares++;
      $display("FAIL overlap_end: occ=%0d exec_rdy=%b src_rdy=%b, required 0 0 1", bus.occ, bus.exec_rdy, bus.src_rdy);
    end
  endtask

  task automatic test_reset_mid();
    logic [ELEM_W-1:0] e;
    fill(32'hE00, 32'hF00, 5, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    exp_err = 1'b0;
    vectors++;
    if (bus.src_rdy !== 1'b1 || bus.exec_rdy !== 1'b0 || bus.occ !== 2'd0) begin
      miscompares++;
      $display("FAIL midreset_rdy: src_rdy=%b exec_rdy=%b occ=%0d, required 1 0 0", bus.src_rdy, bus.exec_rdy, bus.occ);
    end
    vectors++;
    if (bus.d !== 32'h0 || bus.d_v !== 1'b0 || bus.err !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_out: d=%h d_v=%b err=%b, required 0 0 0", bus.d, bus.d_v, bus.err);
    end
    @(negedge clk);
    reset = 1'b0;
    fill(32'hC00, 32'hD00, 16, 1'b1);
    exp_q.delete();
    for (int k = 0; k <= 32; k++) begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        vectors++;
        if (bus.d_v !== 1'b1 || bus.d !== e) begin
          miscompares++;
          $display("FAIL midreset_read ia=%0d: d=%h d_v=%b, required d=%h d_v=1", k - 1, bus.d, bus.d_v, e);
        end
      end
      if (k < 32) begin
        bus.exec = 1'b1;
        bus.ia = 5'(k);
        bus.exec_last = (k == 31);
        exp_q.push_back(elem_of(32'hC00, 32'hD00, k));
      end else begin
        idle();
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill_read();
    test_full();
    test_simultaneous();
    test_exec_empty();
    test_overlap();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
